// File: rtl/wb_sram_pkg.sv
// rtl/wb_sram_pkg.sv - shared types and helpers for the Wishbone-to-SRAM bridge
package wb_sram_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam int LANE_W = 8;

  function automatic int bank_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int lanes(input int data_w);
    return data_w / LANE_W;
  endfunction

endpackage

// File: rtl/wb_sram_bridge_if.sv
// rtl/wb_sram_bridge_if.sv - Wishbone-classic slave bus bundle
interface wb_sram_bridge_if #(
  parameter int DATA_W = 32
);
  logic                wbs_cyc_i;
  logic                wbs_stb_i;
  logic                wbs_we_i;
  logic [DATA_W/8-1:0] wbs_sel_i;
  logic [31:0]         wbs_adr_i;
  logic [DATA_W-1:0]   wbs_dat_i;
  logic                wbs_ack_o;
  logic [DATA_W-1:0]   wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_sram_rd_mux.sv
// rtl/wb_sram_rd_mux.sv - selects one bank's read data from the packed macro outputs
module wb_sram_rd_mux
  import wb_sram_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_BANKS = 2,
  parameter int BANK_W    = bank_w(NUM_BANKS)
) (
  input  logic [NUM_BANKS*DATA_W-1:0] i_dout,
  input  logic [BANK_W-1:0]           i_bank,
  output logic [DATA_W-1:0]           o_dat
);
  always_comb begin
    o_dat = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (i_bank == BANK_W'(b)) o_dat = i_dout[b*DATA_W +: DATA_W];
    end
  end
endmodule

// File: rtl/wb_sram_bridge.sv
// rtl/wb_sram_bridge.sv - Wishbone-classic slave fronting NUM_BANKS single-port SRAM macros
module wb_sram_bridge
  import wb_sram_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 8,
  parameter int          NUM_BANKS = 2,
  parameter int          RD_LAT    = 1,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_0000
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  wb_sram_bridge_if.slave             wbs,
  output logic [NUM_BANKS-1:0]        sram_csb0_o,
  output logic                        sram_web0_o,
  output logic [DATA_W/8-1:0]         sram_wmask0_o,
  output logic [ADDR_W-1:0]           sram_addr0_o,
  output logic [DATA_W-1:0]           sram_din0_o,
  input  logic [NUM_BANKS*DATA_W-1:0] sram_dout0_i
);
  localparam int              LANES    = lanes(DATA_W);
  localparam int              BANK_W   = bank_w(NUM_BANKS);
  localparam int              CNT_W    = 2;
  localparam logic [BANK_W:0] BANK_LIM = (BANK_W + 1)'(NUM_BANKS);

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [BANK_W-1:0]    r_bank, w_bank_nxt;
  logic                 r_we, w_we_nxt;
  logic                 r_ok, w_ok_nxt;
  logic                 r_ack, w_ack_nxt;
  logic [DATA_W-1:0]    r_dat, w_dat_nxt;
  logic [NUM_BANKS-1:0] r_csb, w_csb_nxt;
  logic                 r_web, w_web_nxt;
  logic [LANES-1:0]     r_wmask, w_wmask_nxt;
  logic [ADDR_W-1:0]    r_addr, w_addr_nxt;
  logic [DATA_W-1:0]    r_din, w_din_nxt;

  logic                 w_hit;
  logic                 w_bank_ok;
  logic [BANK_W-1:0]    w_bank;
  logic [ADDR_W-1:0]    w_word;
  logic [DATA_W-1:0]    w_rd_dat;

  assign w_hit     = wbs.wbs_cyc_i & wbs.wbs_stb_i &
                     ((wbs.wbs_adr_i & ADDR_MASK) == BASE_ADDR);
  assign w_word    = wbs.wbs_adr_i[2 +: ADDR_W];
  assign w_bank    = wbs.wbs_adr_i[2+ADDR_W +: BANK_W];
  assign w_bank_ok = {1'b0, w_bank} < BANK_LIM;

  wb_sram_rd_mux #(
    .DATA_W    (DATA_W),
    .NUM_BANKS (NUM_BANKS),
    .BANK_W    (BANK_W)
  ) u_rd_mux (
    .i_dout (sram_dout0_i),
    .i_bank (r_bank),
    .o_dat  (w_rd_dat)
  );

  // Out-of-range hits still pass through ISSUE (with no chip select) so every
  // write-like access acks with the same latency.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bank_nxt  = r_bank;
    w_we_nxt    = r_we;
    w_ok_nxt    = r_ok;
    w_ack_nxt   = 1'b0;
    w_dat_nxt   = r_dat;
    w_csb_nxt   = '1;
    w_web_nxt   = 1'b1;
    w_wmask_nxt = '0;
    w_addr_nxt  = r_addr;
    w_din_nxt   = r_din;
    case (r_state)
      IDLE: begin
        if (w_hit) begin
          w_state_nxt = ISSUE;
          w_bank_nxt  = w_bank;
          w_we_nxt    = wbs.wbs_we_i;
          w_ok_nxt    = w_bank_ok;
          if (w_bank_ok) begin
            w_csb_nxt   = ~(NUM_BANKS'(1) << w_bank);
            w_web_nxt   = ~wbs.wbs_we_i;
            w_wmask_nxt = wbs.wbs_we_i ? wbs.wbs_sel_i : '0;
            w_addr_nxt  = w_word;
            w_din_nxt   = wbs.wbs_dat_i;
          end
        end
      end
      ISSUE: begin
        if (!wbs.wbs_cyc_i) begin
          w_state_nxt = IDLE;
        end else if (r_we || !r_ok) begin
          w_state_nxt = ACK;
          w_ack_nxt   = 1'b1;
          if (!r_we) w_dat_nxt = '0;
        end else begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = CNT_W'(RD_LAT - 1);
        end
      end
      WAIT: begin
        if (!wbs.wbs_cyc_i) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == '0) begin
          w_state_nxt = ACK;
          w_ack_nxt   = 1'b1;
          w_dat_nxt   = w_rd_dat;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bank  <= '0;
      r_we    <= 1'b0;
      r_ok    <= 1'b0;
      r_ack   <= 1'b0;
      r_dat   <= '0;
      r_csb   <= '1;
      r_web   <= 1'b1;
      r_wmask <= '0;
      r_addr  <= '0;
      r_din   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bank  <= w_bank_nxt;
      r_we    <= w_we_nxt;
      r_ok    <= w_ok_nxt;
      r_ack   <= w_ack_nxt;
      r_dat   <= w_dat_nxt;
      r_csb   <= w_csb_nxt;
      r_web   <= w_web_nxt;
      r_wmask <= w_wmask_nxt;
      r_addr  <= w_addr_nxt;
      r_din   <= w_din_nxt;
    end
  end

  assign wbs.wbs_ack_o = r_ack;
  assign wbs.wbs_dat_o = r_dat;
  assign sram_csb0_o   = r_csb;
  assign sram_web0_o   = r_web;
  assign sram_wmask0_o = r_wmask;
  assign sram_addr0_o  = r_addr;
  assign sram_din0_o   = r_din;

endmodule

// File: tb/tb_wb_sram_bridge.sv
// tb/tb_wb_sram_bridge.sv - directed vector bench for wb_sram_bridge with behavioural macro models
module tb_wb_sram_bridge;
  import wb_sram_pkg::*;

  typedef struct {
    string       name;
    bit          dut_b;
    bit          we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [2:0]  e_csb;
    logic        e_web;
    logic [3:0]  e_wmask;
    logic [7:0]  e_addr;
    int          e_ack;
    logic [31:0] e_dat;
  } vec_t;

  logic clk;
  logic rst;

  wb_sram_bridge_if #(.DATA_W(32)) if_a ();
  wb_sram_bridge_if #(.DATA_W(32)) if_b ();

  logic [1:0]  csb_a;
  logic        web_a;
  logic [3:0]  wmask_a;
  logic [7:0]  addr_a;
  logic [31:0] din_a;
  logic [63:0] dout_a;
  logic [2:0]  csb_b;
  logic        web_b;
  logic [3:0]  wmask_b;
  logic [7:0]  addr_b;
  logic [31:0] din_b;
  logic [95:0] dout_b;

  logic [31:0] mem_a [2][256];
  logic [31:0] mem_b [3][256];
  logic [31:0] pend_b [3];
  int          cnt_b [3];

  int   n_vec;
  int   n_bad;
  vec_t vecs [11];

  wb_sram_bridge #(.NUM_BANKS(2), .RD_LAT(1)) dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs(if_a),
    .sram_csb0_o(csb_a), .sram_web0_o(web_a), .sram_wmask0_o(wmask_a),
    .sram_addr0_o(addr_a), .sram_din0_o(din_a), .sram_dout0_i(dout_a)
  );

  wb_sram_bridge #(.NUM_BANKS(3), .RD_LAT(3)) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs(if_b),
    .sram_csb0_o(csb_b), .sram_web0_o(web_b), .sram_wmask0_o(wmask_b),
    .sram_addr0_o(addr_b), .sram_din0_o(din_b), .sram_dout0_i(dout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Macro model, one-cycle read latency.
  always @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int w = 0; w < 256; w++) mem_a[b][w] <= 32'h1122_3344;
        dout_a[b*32 +: 32] <= 32'hBAD0_0000 + 32'(b);
      end
      mem_a[1][4] <= 32'hCAFE_F00D;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (!csb_a[b]) begin
          if (!web_a) begin
            for (int k = 0; k < 4; k++)
              if (wmask_a[k]) mem_a[b][addr_a][k*8 +: 8] <= din_a[k*8 +: 8];
          end else begin
            dout_a[b*32 +: 32] <= mem_a[b][addr_a];
          end
        end
      end
    end
  end

  // Macro model, three-cycle read latency; output is garbage until valid.
  always @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 3; b++) begin
        for (int w = 0; w < 256; w++) mem_b[b][w] <= 32'h5566_7788;
        dout_b[b*32 +: 32] <= 32'hBAD1_0000 + 32'(b);
        pend_b[b] <= '0;
        cnt_b[b]  <= 0;
      end
      mem_b[2][1] <= 32'h1234_5678;
    end else begin
      for (int b = 0; b < 3; b++) begin
        if (!csb_b[b]) begin
          if (!web_b) begin
            for (int k = 0; k < 4; k++)
              if (wmask_b[k]) mem_b[b][addr_b][k*8 +: 8] <= din_b[k*8 +: 8];
          end else begin
            pend_b[b]          <= mem_b[b][addr_b];
            cnt_b[b]           <= 2;
            dout_b[b*32 +: 32] <= 32'hBAD0_BAD0;
          end
        end else if (cnt_b[b] != 0) begin
          cnt_b[b] <= cnt_b[b] - 1;
          if (cnt_b[b] == 1) dout_b[b*32 +: 32] <= pend_b[b];
        end
      end
    end
  end

  function automatic logic ack_of(input bit b);
    return b ? if_b.wbs_ack_o : if_a.wbs_ack_o;
  endfunction
  function automatic logic [31:0] dat_of(input bit b);
    return b ? if_b.wbs_dat_o : if_a.wbs_dat_o;
  endfunction
  function automatic logic [2:0] csb_of(input bit b);
    return b ? csb_b : {1'b1, csb_a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit b, input bit cyc, input bit we, input logic [31:0] adr,
                       input logic [3:0] sel, input logic [31:0] dat);
    if (b) begin
      if_b.wbs_cyc_i = cyc; if_b.wbs_stb_i = cyc; if_b.wbs_we_i = we;
      if_b.wbs_adr_i = adr; if_b.wbs_sel_i = sel; if_b.wbs_dat_i = dat;
    end else begin
      if_a.wbs_cyc_i = cyc; if_a.wbs_stb_i = cyc; if_a.wbs_we_i = we;
      if_a.wbs_adr_i = adr; if_a.wbs_sel_i = sel; if_a.wbs_dat_i = dat;
    end
  endtask

  task automatic await_ack(input bit b, input int budget, output int c_ack);
    c_ack = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (ack_of(b)) begin
        c_ack = c;
        return;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int          c_ack, n_ack, n_csb;
    logic [31:0] dat;
    c_ack = -1; n_ack = 0; n_csb = 0; dat = 'x;
    @(posedge clk); #1;
    drive(v.dut_b, 1'b1, v.we, v.adr, v.sel, v.dat);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk({v.name, ".csb"}, 32'(csb_of(v.dut_b)), 32'(v.e_csb));
        chk({v.name, ".web"}, 32'(v.dut_b ? web_b : web_a), 32'(v.e_web));
        chk({v.name, ".wmask"}, 32'(v.dut_b ? wmask_b : wmask_a), 32'(v.e_wmask));
        if (v.e_csb != 3'b111)
          chk({v.name, ".addr"}, 32'(v.dut_b ? addr_b : addr_a), 32'(v.e_addr));
      end
      if (csb_of(v.dut_b) != 3'b111) n_csb++;
      if (ack_of(v.dut_b)) begin
        n_ack++;
        if (c_ack < 0) begin
          c_ack = c;
          dat   = dat_of(v.dut_b);
        end
      end
      @(posedge clk); #1;
      if (c_ack >= 0) drive(v.dut_b, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    end
    drive(v.dut_b, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    chk({v.name, ".ack_cycle"}, 32'(c_ack), 32'(v.e_ack));
    chk({v.name, ".ack_count"}, 32'(n_ack), 32'd1);
    chk({v.name, ".csb_cycles"}, 32'(n_csb), (v.e_csb != 3'b111) ? 32'd1 : 32'd0);
    chk({v.name, ".dat"}, dat, v.e_dat);
  endtask

  initial begin
    int c, n_ack, n_csb;
    n_vec = 0;
    n_bad = 0;
    rst   = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    vecs[0]  = '{"w_full",     1'b0, 1'b1, 32'h3000_0010, 4'hF, 32'hDEAD_BEEF, 3'b110, 1'b0, 4'hF, 8'h04, 2, 32'h0000_0000};
    vecs[1]  = '{"rd_bank1",   1'b0, 1'b0, 32'h3000_0410, 4'h0, 32'h0,         3'b101, 1'b1, 4'h0, 8'h04, 3, 32'hCAFE_F00D};
    vecs[2]  = '{"w_byte1",    1'b0, 1'b1, 32'h3000_0020, 4'h2, 32'h0000_AB00, 3'b110, 1'b0, 4'h2, 8'h08, 2, 32'hCAFE_F00D};
    vecs[3]  = '{"rd_byte1",   1'b0, 1'b0, 32'h3000_0020, 4'hF, 32'h0,         3'b110, 1'b1, 4'h0, 8'h08, 3, 32'h1122_AB44};
    vecs[4]  = '{"rd_full",    1'b0, 1'b0, 32'h3000_0010, 4'h0, 32'h0,         3'b110, 1'b1, 4'h0, 8'h04, 3, 32'hDEAD_BEEF};
    vecs[5]  = '{"w_sel0",     1'b0, 1'b1, 32'h3000_0020, 4'h0, 32'hFFFF_FFFF, 3'b110, 1'b0, 4'h0, 8'h08, 2, 32'hDEAD_BEEF};
    vecs[6]  = '{"rd_sel0",    1'b0, 1'b0, 32'h3000_0020, 4'h0, 32'h0,         3'b110, 1'b1, 4'h0, 8'h08, 3, 32'h1122_AB44};
    vecs[7]  = '{"b_rd_bank2", 1'b1, 1'b0, 32'h3000_0804, 4'h0, 32'h0,         3'b011, 1'b1, 4'h0, 8'h01, 5, 32'h1234_5678};
    vecs[8]  = '{"b_w_oor",    1'b1, 1'b1, 32'h3000_0C00, 4'hF, 32'hAAAA_5555, 3'b111, 1'b1, 4'h0, 8'h00, 2, 32'h1234_5678};
    vecs[9]  = '{"b_rd_oor",   1'b1, 1'b0, 32'h3000_0C04, 4'h0, 32'h0,         3'b111, 1'b1, 4'h0, 8'h00, 2, 32'h0000_0000};
    vecs[10] = '{"b_rd_bank0", 1'b1, 1'b0, 32'h3000_0000, 4'h0, 32'h0,         3'b110, 1'b1, 4'h0, 8'h00, 5, 32'h5566_7788};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack_a",   32'(if_a.wbs_ack_o), 32'd0);
    chk("rst_dat_a",   if_a.wbs_dat_o,      32'd0);
    chk("rst_csb_a",   32'(csb_a),          32'h3);
    chk("rst_web_a",   32'(web_a),          32'd1);
    chk("rst_wmask_a", 32'(wmask_a),        32'd0);
    chk("rst_addr_a",  32'(addr_a),         32'd0);
    chk("rst_din_a",   din_a,               32'd0);
    chk("rst_csb_b",   32'(csb_b),          32'h7);
    chk("rst_ack_b",   32'(if_b.wbs_ack_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Back-to-back: read issued in the cycle right after the write's ack.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 32'h3000_0414, 4'hF, 32'h0A0B_0C0D);
    await_ack(1'b0, 10, c);
    chk("b2b_wr_ack", 32'(c), 32'd2);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 32'h3000_0414, 4'h0, 32'h0);
    await_ack(1'b0, 10, c);
    chk("b2b_rd_ack", 32'(c), 32'd3);
    chk("b2b_rd_dat", dat_of(1'b0), 32'h0A0B_0C0D);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    // Abort: drop cyc while the slow bank is in WAIT.
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 32'h3000_0000, 4'h0, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_ack",   32'(if_b.wbs_ack_o), 32'd0);
    chk("abort_csb",   32'(csb_b),          32'h7);
    chk("abort_state", 32'(dut_b.r_state),  32'(IDLE));
    n_ack = 0;
    repeat (5) begin
      @(negedge clk);
      if (if_b.wbs_ack_o) n_ack++;
    end
    chk("abort_late_ack", 32'(n_ack), 32'd0);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 32'h3000_0804, 4'h0, 32'h0);
    await_ack(1'b1, 12, c);
    chk("post_abort_ack", 32'(c), 32'd5);
    chk("post_abort_dat", dat_of(1'b1), 32'h1234_5678);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    // Asynchronous reset in the middle of WAIT.
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 32'h3000_0000, 4'h0, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_ack",   32'(if_b.wbs_ack_o), 32'd0);
    chk("midrst_csb",   32'(csb_b),          32'h7);
    chk("midrst_dat_b", if_b.wbs_dat_o,      32'd0);
    chk("midrst_dat_a", if_a.wbs_dat_o,      32'd0);
    chk("midrst_state", 32'(dut_b.r_state),  32'(IDLE));
    drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Address outside the window is ignored.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 32'h2000_0000, 4'hF, 32'h0);
    n_ack = 0;
    n_csb = 0;
    repeat (6) begin
      @(negedge clk);
      if (if_a.wbs_ack_o) n_ack++;
      if (csb_a != 2'b11) n_csb++;
    end
    chk("nowin_ack", 32'(n_ack), 32'd0);
    chk("nowin_csb", 32'(n_csb), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
